// File: rtl/rs_pkg.sv
// Shared GF(2^8) arithmetic and constants for the RS(68,64) encoder/decoder pair.
// Field: primitive polynomial 0x11D, alpha = 0x02; log/exp tables are built at elaboration.
package rs_pkg;

    localparam int         GF_W    = 8;
    localparam logic [8:0] GF_POLY = 9'h11D;
    localparam int         N       = 68;
    localparam int         K       = 64;
    localparam int         NSYM    = N - K;

    typedef enum logic [1:0] {ACCUM, EVAL1, EVAL2, OUT} state_e;

    function automatic logic [GF_W-1:0] gf_mul_a1(input logic [GF_W-1:0] x);
        return {x[GF_W-2:0], 1'b0} ^ (x[GF_W-1] ? GF_POLY[GF_W-1:0] : '0);
    endfunction

    function automatic logic [GF_W-1:0] gf_mul_a2(input logic [GF_W-1:0] x);
        return gf_mul_a1(gf_mul_a1(x));
    endfunction

    function automatic logic [GF_W-1:0] gf_mul_a3(input logic [GF_W-1:0] x);
        return gf_mul_a1(gf_mul_a2(x));
    endfunction

    function automatic logic [255:0][GF_W-1:0] gf_gen_exp();
        logic [255:0][GF_W-1:0] t;
        logic [GF_W-1:0]        x;
        x = 8'h01;
        for (int i = 0; i < 256; i++) begin
            t[i] = x;
            x    = gf_mul_a1(x);
        end
        return t;
    endfunction

    // log(0) is left at 0; every caller bypasses zero operands.
    function automatic logic [255:0][GF_W-1:0] gf_gen_log();
        logic [255:0][GF_W-1:0] t;
        logic [GF_W-1:0]        x;
        t = '0;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            t[x] = i[GF_W-1:0];
            x    = gf_mul_a1(x);
        end
        return t;
    endfunction

    localparam logic [255:0][GF_W-1:0] GF_EXP = gf_gen_exp();
    localparam logic [255:0][GF_W-1:0] GF_LOG = gf_gen_log();

    function automatic logic [GF_W-1:0] gf_mul(input logic [GF_W-1:0] a, input logic [GF_W-1:0] b);
        logic [8:0] s;
        s = {1'b0, GF_LOG[a]} + {1'b0, GF_LOG[b]};
        if (s >= 9'd255) s = s - 9'd255;
        return (a == '0 || b == '0) ? '0 : GF_EXP[s[7:0]];
    endfunction

endpackage

// File: rtl/rs_syndrome_acc.sv
// Four-lane Horner accumulator: S_j <= S_j * alpha^j ^ data per enabled symbol.
// load_i starts a new codeword by loading data directly into every lane.
module rs_syndrome_acc
    import rs_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic [7:0] syn_o [NSYM]
);

    logic [7:0] syn_q [NSYM];
    logic [7:0] syn_d [NSYM];

    always_comb begin
        syn_d[0] = load_i ? data_i : syn_q[0] ^ data_i;
        syn_d[1] = load_i ? data_i : gf_mul_a1(syn_q[1]) ^ data_i;
        syn_d[2] = load_i ? data_i : gf_mul_a2(syn_q[2]) ^ data_i;
        syn_d[3] = load_i ? data_i : gf_mul_a3(syn_q[3]) ^ data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NSYM; j++) syn_q[j] <= '0;
        end else if (en_i) begin
            syn_q <= syn_d;
        end
    end

    assign syn_o = syn_q;

endmodule

// File: rtl/rs_syndrome_decoder.sv
// RS(68,64) receive-side syndrome computation and single-symbol error classifier.
// State table: ACCUM | taking symbols   EVAL1 | logs/products   EVAL2 | classify   OUT | result held until out_ready
module rs_syndrome_decoder
    import rs_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] syn_out [NSYM],
    output logic       err_none,
    output logic       err_single,
    output logic       err_uncorr,
    output logic [6:0] err_pos,
    output logic       frame_err,
    output logic [7:0] err_mag,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam logic [6:0] LAST_IDX = 7'(N - 1);

    state_e     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic       frame_q, frame_d;
    logic       accept;
    logic [7:0] syn [NSYM];

    logic [7:0] log0_q, log1_q;
    logic [3:0] nz_q;
    logic [7:0] p11_q, p02_q, p22_q, p13_q;
    logic       none_q, single_q, uncorr_q;
    logic [6:0] pos_q;
    logic [7:0] mag_q;

    logic [8:0] diff, l_val;
    logic       none_c, single_c;

    assign in_ready = (state_q == ACCUM);
    assign accept   = in_valid & in_ready;

    rs_syndrome_acc u_acc (
        .clk    (clk),
        .rst    (rst),
        .en_i   (accept),
        .load_i (cnt_q == 7'd0),
        .data_i (in_data),
        .syn_o  (syn)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_q + 7'd1;
                    if (in_last || cnt_q == LAST_IDX) begin
                        state_d = EVAL1;
                        frame_d = in_last ^ (cnt_q == LAST_IDX);
                    end
                end
            end
            EVAL1: state_d = EVAL2;
            EVAL2: state_d = OUT;
            OUT: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
        end
    end

    // L = (log S1 - log S0) mod 255 is the error's power of x; 67 - L gives the stream index.
    always_comb begin
        diff     = {1'b0, log1_q} - {1'b0, log0_q};
        l_val    = diff[8] ? diff + 9'd255 : diff;
        none_c   = (nz_q == 4'b0000);
        single_c = (&nz_q) && (p11_q == p02_q) && (p22_q == p13_q) && (l_val <= 9'd67);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            log0_q   <= '0;
            log1_q   <= '0;
            nz_q     <= '0;
            p11_q    <= '0;
            p02_q    <= '0;
            p22_q    <= '0;
            p13_q    <= '0;
            none_q   <= 1'b0;
            single_q <= 1'b0;
            uncorr_q <= 1'b0;
            pos_q    <= '0;
            mag_q    <= '0;
        end else if (state_q == EVAL1) begin
            log0_q <= GF_LOG[syn[0]];
            log1_q <= GF_LOG[syn[1]];
            nz_q   <= {syn[3] != 8'h00, syn[2] != 8'h00, syn[1] != 8'h00, syn[0] != 8'h00};
            p11_q  <= gf_mul(syn[1], syn[1]);
            p02_q  <= gf_mul(syn[0], syn[2]);
            p22_q  <= gf_mul(syn[2], syn[2]);
            p13_q  <= gf_mul(syn[1], syn[3]);
        end else if (state_q == EVAL2) begin
            none_q   <= none_c & ~frame_q;
            single_q <= single_c & ~frame_q;
            uncorr_q <= frame_q | ~(none_c | single_c);
            pos_q    <= 7'd67 - l_val[6:0];
            mag_q    <= syn[0];
        end
    end

    assign syn_out    = syn;
    assign err_none   = none_q;
    assign err_single = single_q;
    assign err_uncorr = uncorr_q;
    assign err_pos    = pos_q;
    assign err_mag    = mag_q;
    assign frame_err  = frame_q;
    assign out_valid  = (state_q == OUT);

endmodule

// File: tb/tb_rs_syndrome_decoder.sv
// Directed + randomized bench for rs_syndrome_decoder against a polynomial-evaluation model.
module tb_rs_syndrome_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid, in_last, in_ready;
    logic [7:0] syn_out [4];
    logic       err_none, err_single, err_uncorr, frame_err, out_valid, out_ready;
    logic [6:0] err_pos;
    logic [7:0] err_mag;

    int ntests = 0;
    int nfail  = 0;

    logic [7:0] cw   [68];
    logic [7:0] apow [255];
    logic [7:0] gen  [5];
    logic [7:0] es   [4];
    logic       enone, esingle, euncorr, eframe;
    logic [6:0] epos;
    logic [7:0] emag;

    always #5 clk = ~clk;

    rs_syndrome_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .syn_out    (syn_out),
        .err_none   (err_none),
        .err_single (err_single),
        .err_uncorr (err_uncorr),
        .err_pos    (err_pos),
        .frame_err  (frame_err),
        .err_mag    (err_mag),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    // Shift-and-add field multiply, independent of any table.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cw();
        for (int i = 0; i < 68; i++) cw[i] = 8'h00;
    endtask

    // Systematic encoder: random message then remainder of m(x)*x^4 mod g(x).
    task automatic encode_random();
        logic [7:0] r [4];
        logic [7:0] fb;
        for (int i = 0; i < 4; i++) r[i] = 8'h00;
        for (int i = 0; i < 64; i++) begin
            cw[i] = 8'($urandom);
            fb    = cw[i] ^ r[3];
            r[3]  = r[2] ^ gmul(fb, gen[3]);
            r[2]  = r[1] ^ gmul(fb, gen[2]);
            r[1]  = r[0] ^ gmul(fb, gen[1]);
            r[0]  = gmul(fb, gen[0]);
        end
        for (int i = 0; i < 4; i++) cw[64 + i] = r[3 - i];
    endtask

    // Evaluate the received polynomial at alpha^j, then search every position for a single-error fit.
    task automatic model(input int n, input logic fr);
        logic [7:0] s;
        logic       ok;
        for (int j = 0; j < 4; j++) begin
            s = 8'h00;
            for (int k = 0; k < n; k++) s = s ^ gmul(cw[k], apow[(j * (n - 1 - k)) % 255]);
            es[j] = s;
        end
        eframe  = fr;
        enone   = 1'b0;
        esingle = 1'b0;
        euncorr = 1'b0;
        epos    = '0;
        emag    = '0;
        if (fr) begin
            euncorr = 1'b1;
        end else if (es[0] == 0 && es[1] == 0 && es[2] == 0 && es[3] == 0) begin
            enone = 1'b1;
        end else begin
            for (int p = 0; p < 68; p++) begin
                ok = (es[0] != 8'h00);
                for (int j = 0; j < 4; j++)
                    if (es[j] != gmul(es[0], apow[(j * (67 - p)) % 255])) ok = 1'b0;
                if (ok && !esingle) begin
                    esingle = 1'b1;
                    epos    = 7'(p);
                    emag    = es[0];
                end
            end
            euncorr = ~esingle;
        end
    endtask

    task automatic send(input int n, input int last_at, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                    in_data  = 8'($urandom);
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_data  = cw[i];
            in_last  = (i == last_at);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag);
        int lat;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'd3);
        for (int j = 0; j < 4; j++) chk($sformatf("%s.S%0d", tag, j), 32'(syn_out[j]), 32'(es[j]));
        chk({tag, ".err_none"}, 32'(err_none), 32'(enone));
        chk({tag, ".err_single"}, 32'(err_single), 32'(esingle));
        chk({tag, ".err_uncorr"}, 32'(err_uncorr), 32'(euncorr));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(eframe));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
        if (esingle) begin
            chk({tag, ".err_pos"}, 32'(err_pos), 32'(epos));
            chk({tag, ".err_mag"}, 32'(err_mag), 32'(emag));
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        apow[0] = 8'h01;
        for (int k = 1; k < 255; k++) apow[k] = gmul(apow[k - 1], 8'h02);
        gen[0] = 8'h01;
        for (int k = 1; k < 5; k++) gen[k] = 8'h00;
        for (int r = 0; r < 4; r++) begin
            for (int k = 4; k >= 1; k--) gen[k] = gen[k - 1] ^ gmul(apow[r], gen[k]);
            gen[0] = gmul(apow[r], gen[0]);
        end

        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.S0", 32'(syn_out[0]), 32'd0);
        chk("reset.S3", 32'(syn_out[3]), 32'd0);
        chk("reset.flags", 32'({err_none, err_single, err_uncorr, frame_err}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        clear_cw();
        model(68, 1'b0);
        send(68, 67, 1'b0);
        check_result("zero_cw");
        handshake("zero_cw");

        clear_cw();
        cw[67] = 8'h05;
        model(68, 1'b0);
        send(68, 67, 1'b0);
        check_result("err_at_67");
        handshake("err_at_67");

        clear_cw();
        cw[66] = 8'h01;
        model(68, 1'b0);
        send(68, 67, 1'b0);
        check_result("err_at_66");
        handshake("err_at_66");

        clear_cw();
        cw[66] = 8'h01;
        cw[67] = 8'h01;
        model(68, 1'b0);
        send(68, 67, 1'b0);
        check_result("double_err");
        handshake("double_err");

        encode_random();
        model(10, 1'b1);
        send(10, 9, 1'b0);
        check_result("short_frame");
        handshake("short_frame");

        encode_random();
        model(68, 1'b0);
        send(68, 67, 1'b1);
        check_result("clean_after_short");
        chk("clean_after_short.none_req", 32'(err_none), 32'd1);
        handshake("clean_after_short");

        for (int t = 0; t < 8; t++) begin
            int nerr;
            encode_random();
            nerr = $urandom_range(0, 2);
            for (int e = 0; e < nerr; e++) cw[$urandom_range(0, 67)] ^= 8'($urandom_range(1, 255));
            model(68, 1'b0);
            send(68, 67, 1'b1);
            check_result($sformatf("rand%0d", t));
            handshake($sformatf("rand%0d", t));
        end

        encode_random();
        model(68, 1'b1);
        send(68, -1, 1'b0);
        check_result("missing_last");
        handshake("missing_last");

        encode_random();
        cw[20] ^= 8'h3C;
        model(68, 1'b0);
        out_ready = 1'b0;
        send(68, 67, 1'b0);
        check_result("stall");
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
            chk("stall.out_valid", 32'(out_valid), 32'd1);
            chk("stall.in_ready", 32'(in_ready), 32'd0);
            chk("stall.err_single", 32'(err_single), 32'(esingle));
            chk("stall.err_pos", 32'(err_pos), 32'(epos));
            chk("stall.S1", 32'(syn_out[1]), 32'(es[1]));
        end
        in_valid = 1'b0;
        handshake("stall");

        encode_random();
        model(68, 1'b0);
        send(68, 67, 1'b0);
        check_result("after_stall");
        chk("after_stall.none_req", 32'(err_none), 32'd1);
        handshake("after_stall");

        encode_random();
        send(30, -1, 1'b0);
        rst = 1'b1;
        #1;
        chk("midreset.out_valid", 32'(out_valid), 32'd0);
        chk("midreset.in_ready", 32'(in_ready), 32'd1);
        chk("midreset.S2", 32'(syn_out[2]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        encode_random();
        model(68, 1'b0);
        send(68, 67, 1'b1);
        check_result("post_reset");
        chk("post_reset.none_req", 32'(err_none), 32'd1);
        handshake("post_reset");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
